// File: rtl/sap_pkg.sv
// sap_pkg: shared constants and helpers for the buffered demux router.
package sap_pkg;
  localparam int DEF_WIDTH = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register with pass-through ready.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             free
);
  assign free = ~out_valid | out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load) out_data <= data;
      out_valid <= load | (out_valid & ~out_ready);
    end
  end
endmodule

// File: rtl/demux_router_buffered.sv
// demux_router_buffered: routes words to per-channel holding slots with broadcast and drop accounting.
module demux_router_buffered
  import sap_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = clog2(CHANNELS),
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      err_sel,
  output logic [CNT_W-1:0]          drop_count
);
  localparam logic [SEL_W:0] CH = (SEL_W + 1)'(CHANNELS);
  logic [CHANNELS-1:0] free;
  logic in_range, xfer, drop;
  assign in_range = {1'b0, in_sel} < CH;
  always_comb in_ready = rst ? 1'b0 : in_bcast ? &free : in_range ? free[in_sel] : 1'b1;
  assign xfer = in_valid & in_ready;
  assign drop = xfer & ~in_bcast & ~in_range;
  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (xfer & (in_bcast | (in_range & (in_sel == SEL_W'(k))))),
      .data      (in_data),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k*WIDTH +: WIDTH]),
      .out_valid (out_valid[k]),
      .free      (free[k])
    );
  end
  // counter sticks at all-ones; the error pulse still fires
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sel    <= 1'b0;
      drop_count <= '0;
    end else begin
      err_sel <= drop;
      if (drop && !(&drop_count)) drop_count <= drop_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_demux_router_buffered.sv
// tb_demux_router_buffered: checks a 16-channel and a 12-channel/2-bit-counter router against a reference model.
module tb_demux_router_buffered;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        iv[2];
  logic [7:0]  idat[2];
  logic [3:0]  isel[2];
  logic        ib[2];
  logic [15:0] ordy[2];
  logic a_rdy, b_rdy, a_err, b_err;
  logic [127:0] a_od;
  logic [95:0]  b_od;
  logic [15:0]  a_ov;
  logic [11:0]  b_ov;
  logic [7:0]   a_cnt;
  logic [1:0]   b_cnt;
  demux_router_buffered dut_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(a_rdy), .in_data(idat[0]),
    .in_sel(isel[0]), .in_bcast(ib[0]), .out_data(a_od), .out_valid(a_ov),
    .out_ready(ordy[0]), .err_sel(a_err), .drop_count(a_cnt)
  );
  demux_router_buffered #(.CHANNELS(12), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(b_rdy), .in_data(idat[1]),
    .in_sel(isel[1]), .in_bcast(ib[1]), .out_data(b_od), .out_valid(b_ov),
    .out_ready(ordy[1][11:0]), .err_sel(b_err), .drop_count(b_cnt)
  );
  int nchk = 0;
  int nfail = 0;
  int nch[2] = '{16, 12};
  int cmax[2] = '{255, 3};
  bit mv[2][16];
  logic [7:0] md[2][16];
  int mc[2];
  bit me[2];
  bit lx[2];
  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    nchk++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  // reference: slots are a flag plus word each, counter is a clamped integer
  task automatic model(input int id, output bit rdy);
    bit fr[16];
    bit all, inr, x;
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        mv[id][k] = 0;
        md[id][k] = 0;
      end
      mc[id] = 0;
      me[id] = 0;
      lx[id] = 0;
      rdy = 0;
      return;
    end
    all = 1;
    for (int k = 0; k < 16; k++) fr[k] = 1;
    for (int k = 0; k < nch[id]; k++) begin
      fr[k] = !mv[id][k] || ordy[id][k];
      all &= fr[k];
    end
    inr = int'(isel[id]) < nch[id];
    rdy = ib[id] ? all : inr ? fr[isel[id]] : 1'b1;
    x = iv[id] && rdy;
    for (int k = 0; k < nch[id]; k++) begin
      if (mv[id][k] && ordy[id][k]) mv[id][k] = 0;
      if (x && (ib[id] || (inr && int'(isel[id]) == k))) begin
        mv[id][k] = 1;
        md[id][k] = idat[id];
      end
    end
    me[id] = x && !ib[id] && !inr;
    if (me[id] && mc[id] < cmax[id]) mc[id]++;
    lx[id] = x;
  endtask
  task automatic step();
    bit r;
    logic [15:0] ev;
    logic [127:0] ed;
    @(negedge clk);
    for (int id = 0; id < 2; id++) begin
      model(id, r);
      chk($sformatf("in_ready%0d", id), id == 0 ? 128'(a_rdy) : 128'(b_rdy), 128'(r));
    end
    @(posedge clk);
    #1;
    for (int id = 0; id < 2; id++) begin
      ev = '0;
      ed = '0;
      for (int k = 0; k < nch[id]; k++) begin
        ev[k] = mv[id][k];
        ed[k*8 +: 8] = md[id][k];
      end
      chk($sformatf("out_valid%0d", id), id == 0 ? 128'(a_ov) : 128'(b_ov), 128'(ev));
      chk($sformatf("out_data%0d", id), id == 0 ? a_od : 128'(b_od), ed);
      chk($sformatf("err_sel%0d", id), id == 0 ? 128'(a_err) : 128'(b_err), 128'(me[id]));
      chk($sformatf("drop_count%0d", id), id == 0 ? 128'(a_cnt) : 128'(b_cnt), 128'(mc[id]));
    end
  endtask
  task automatic drv(input int id, input bit v, input logic [7:0] d, input logic [3:0] s, input bit b);
    iv[id] = v;
    idat[id] = d;
    isel[id] = s;
    ib[id] = b;
  endtask
  initial begin
    for (int id = 0; id < 2; id++) begin
      drv(id, 0, 8'h00, 4'd0, 0);
      ordy[id] = 16'hFFFF;
    end
    step();
    step();
    rst = 0;
    for (int s = 0; s < 16; s++) begin
      drv(0, 1, 8'd7, 4'(s), 0);
      drv(1, 1, 8'd7, 4'(s), 0);
      step();
    end
    drv(0, 0, 8'd0, 4'd0, 0);
    for (int s = 0; s < 5; s++) begin
      drv(1, 1, 8'(s), 4'(12 + s % 4), 0);
      step();
    end
    drv(1, 0, 8'd0, 4'd0, 0);
    step();
    ordy[0] = 16'hFFF7;
    drv(0, 1, 8'hA5, 4'd3, 0);
    step();
    drv(0, 1, 8'h5A, 4'd3, 0);
    step();
    step();
    ordy[0] = 16'hFFFF;
    step();
    drv(0, 0, 8'h00, 4'd0, 0);
    step();
    drv(0, 1, 8'h3C, 4'd0, 1);
    drv(1, 1, 8'hC3, 4'd0, 1);
    step();
    ordy[0] = 16'hFDFF;
    ordy[1] = 16'hFDFF;
    drv(0, 1, 8'h11, 4'd2, 1);
    drv(1, 1, 8'h22, 4'd2, 1);
    step();
    step();
    ordy[0] = 16'hFFFF;
    ordy[1] = 16'hFFFF;
    step();
    drv(1, 0, 8'h00, 4'd0, 0);
    ordy[0] = 16'h0000;
    for (int s = 0; s < 4; s++) begin
      drv(0, 1, 8'(8'h40 + s), 4'(s), 0);
      step();
    end
    drv(0, 1, 8'h99, 4'd5, 0);
    rst = 1;
    step();
    rst = 0;
    step();
    ordy[0] = 16'hFFFF;
    for (int c = 0; c < 600; c++) begin
      for (int id = 0; id < 2; id++) begin
        if (!iv[id] || lx[id])
          drv(id, ($urandom % 4) != 0, 8'($urandom), 4'($urandom), ($urandom % 10) == 0);
        ordy[id] = 16'($urandom | $urandom);
      end
      rst = ($urandom % 150) == 0;
      step();
    end
    rst = 0;
    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
endmodule
